// File: rtl/jtag_pkg.sv
// jtag_pkg: shared command encodings, instruction codes and TMS header tables for the JTAG host.
package jtag_pkg;
  typedef enum logic [1:0] {CMD_RST = 2'b00, CMD_IR = 2'b01, CMD_DR = 2'b10, CMD_IDLE = 2'b11} cmd_e;
  typedef enum logic [2:0] {BOOT_RST, IDLE, PRE, SHIFT, POST, RESP} state_e;
  localparam logic [3:0] INS_BYPASS = 4'b0001;
  localparam logic [3:0] INS_IDCODE = 4'b0010;
  localparam logic [3:0] INS_CONFIG = 4'b0100;
  localparam logic [31:0] JTAG_IDCODE = 32'h4A7C_0E1D;
  localparam int HDR_IR = 4;
  localparam int HDR_DR = 3;
  localparam int HDR_RST = 6;
  localparam int HDR_POST = 2;
  // Header TMS from Run-Test/Idle: IR 1100, DR 100, reset 111110, idle all zeros.
  function automatic logic hdr_tms(input cmd_e t, input int i);
    return (t == CMD_IR) ? (i < 2) : (t == CMD_DR) ? (i == 0) : (t == CMD_RST) ? (i < 5) : 1'b0;
  endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK, flags the edges that start each low and high phase.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] cnt_q, cnt_d;
  logic tck_q, tck_d, run_q, wrap;
  assign wrap = run_q && cnt_q == DW'(CLK_DIV - 1);
  // The first enabled edge opens a low phase so the caller can present TMS before the first rise.
  assign fall = en && (!run_q || (wrap && tck_q));
  assign rise = en && wrap && !tck_q;
  assign tck = tck_q;
  always_comb begin
    cnt_d = (!en || !run_q || wrap) ? '0 : cnt_q + 1'b1;
    tck_d = en && (wrap ? !tck_q : tck_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
      run_q <= en;
    end
  end
endmodule

// File: rtl/jtag_master.sv
// jtag_master: JTAG host that turns IR/DR/reset/idle commands into TCK/TMS/TDI sequences and returns TDO.
module jtag_master import jtag_pkg::*; #(
  parameter int MAX_LEN = 32,
  parameter int IR_LEN = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iCmdValid,
  output logic                         oCmdReady,
  input  logic [1:0]                   iCmdType,
  input  logic [$clog2(MAX_LEN+1)-1:0] iCmdLen,
  input  logic [MAX_LEN-1:0]           iCmdData,
  output logic                         oRspValid,
  input  logic                         iRspReady,
  output logic [MAX_LEN-1:0]           oRspData,
  output logic                         oTck,
  output logic                         oTms,
  output logic                         oTdi,
  input  logic                         iTdo
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = LW + 1;
  state_e state_q, state_d;
  cmd_e typ_q, typ_d;
  logic [CW-1:0] n_q, n_d, cnt_q, cnt_d, hdr;
  logic [MAX_LEN-1:0] data_q, data_d, rsp_q, rsp_d, dsh;
  logic tms_q, tms_d, tdi_q, tdi_d, en, rise, fall;
  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (.clk(iClk), .rst(iRst), .en(en), .tck(oTck), .rise(rise), .fall(fall));
  assign en = state_q inside {BOOT_RST, PRE, SHIFT, POST};
  assign hdr = (typ_q == CMD_IR) ? CW'(HDR_IR) : (typ_q == CMD_DR) ? CW'(HDR_DR) :
               (typ_q == CMD_RST) ? CW'(HDR_RST) : n_q;
  assign dsh = data_q >> cnt_q;
  assign oCmdReady = state_q == IDLE;
  assign oRspValid = state_q == RESP;
  assign oRspData = rsp_q;
  assign oTms = tms_q;
  assign oTdi = tdi_q;
  always_comb begin
    state_d = state_q;
    typ_d = typ_q;
    n_d = n_q;
    data_d = data_q;
    rsp_d = rsp_q;
    cnt_d = cnt_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    unique case (state_q)
      BOOT_RST: if (fall) begin
        if (cnt_q < CW'(HDR_RST)) begin
          tms_d = hdr_tms(CMD_RST, int'(cnt_q));
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      IDLE: if (iCmdValid) begin
        typ_d = cmd_e'(iCmdType);
        data_d = iCmdData;
        rsp_d = '0;
        cnt_d = '0;
        n_d = (iCmdType == CMD_IR) ? CW'(IR_LEN) :
              (iCmdType != CMD_DR) ? CW'(iCmdLen) :
              (iCmdLen == '0) ? CW'(1) :
              (CW'(iCmdLen) > CW'(MAX_LEN)) ? CW'(MAX_LEN) : CW'(iCmdLen);
        state_d = (iCmdType == CMD_IDLE && iCmdLen == '0) ? RESP : PRE;
      end
      PRE: if (fall) begin
        if (cnt_q < hdr) begin
          tms_d = hdr_tms(typ_q, int'(cnt_q));
          tdi_d = 1'b0;
          cnt_d = cnt_q + 1'b1;
        end else if (typ_q inside {CMD_IR, CMD_DR}) begin
          state_d = SHIFT;
          tms_d = n_q == CW'(1);
          tdi_d = data_q[0];
          cnt_d = CW'(1);
        end else begin
          state_d = RESP;
        end
      end
      SHIFT: begin
        if (rise) rsp_d = rsp_q | (MAX_LEN'(iTdo) << (cnt_q - 1'b1));
        if (fall) begin
          if (cnt_q < n_q) begin
            tms_d = cnt_q == n_q - 1'b1;
            tdi_d = dsh[0];
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = POST;
            tms_d = 1'b1;
            tdi_d = 1'b0;
            cnt_d = CW'(1);
          end
        end
      end
      POST: if (fall) begin
        if (cnt_q < CW'(HDR_POST)) begin
          tms_d = 1'b0;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: if (iRspReady) state_d = IDLE;
      default: state_d = BOOT_RST;
    endcase
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= BOOT_RST;
      typ_q <= CMD_RST;
      n_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      rsp_q <= '0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q <= typ_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      rsp_q <= rsp_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end
endmodule
